// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path:
// controller states, alignment constants and address helpers.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam logic [1:0] WORD_ALIGN_MASK        = 2'b00;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 16;

  function automatic logic isWordAligned(input logic [31:0] byteAddr);
    return byteAddr[1:0] == WORD_ALIGN_MASK;
  endfunction

  function automatic logic [31:0] wordAddr(input logic [31:0] byteAddr);
    return {byteAddr[31:2], WORD_ALIGN_MASK};
  endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory master: turns EX/MEM load/store requests into a
// req/ack bus transaction, stalls the pipeline meanwhile, and flags errors.
module dmem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  memState_t        state;
  memState_t        nextState;
  logic [31:0]      addrQ;
  logic [31:0]      wdataQ;
  logic             weQ;
  logic [CNT_W-1:0] waitCnt;
  logic [31:0]      rdataQ;
  logic             rdValidQ;
  logic             errQ;
  logic             misQ;

  logic acc;
  logic aligned;
  logic startAcc;
  logic finishAck;
  logic finishTimeout;
  logic misDetect;

  assign acc     = mem_read_i | mem_write_i;
  assign aligned = isWordAligned(addr_i);

  // The IDLE-cycle stall is gated by rst so that reset releases the
  // pipeline immediately even while EX/MEM still presents an access.
  always_comb begin
    nextState     = state;
    stall_o       = 1'b0;
    bus_req_o     = 1'b0;
    startAcc      = 1'b0;
    finishAck     = 1'b0;
    finishTimeout = 1'b0;
    misDetect     = 1'b0;
    case (state)
      IDLE: begin
        if (acc && !rst) begin
          if (aligned) begin
            stall_o   = 1'b1;
            startAcc  = 1'b1;
            nextState = REQ;
          end else begin
            misDetect = 1'b1;
          end
        end
      end
      REQ: begin
        bus_req_o = 1'b1;
        stall_o   = 1'b1;
        if (bus_ack_i) begin
          finishAck = 1'b1;
          nextState = DONE;
        end else if (waitCnt == TIMEOUT_LAST) begin
          finishTimeout = 1'b1;
          nextState     = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Request latches hold the bus stable for the whole REQ phase, since
  // the EX/MEM inputs are frozen only by the stall this block produces.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrQ   <= '0;
      wdataQ  <= '0;
      weQ     <= 1'b0;
      waitCnt <= '0;
    end else if (startAcc) begin
      addrQ   <= wordAddr(addr_i);
      wdataQ  <= wdata_i;
      weQ     <= mem_write_i;
      waitCnt <= '0;
    end else if (state == REQ && !finishAck && !finishTimeout) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  // A timed-out read returns zero so MEM/WB never sees stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdataQ <= '0;
    end else if (finishAck && !weQ) begin
      rdataQ <= bus_rdata_i;
    end else if (finishTimeout && !weQ) begin
      rdataQ <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValidQ <= 1'b0;
      errQ     <= 1'b0;
      misQ     <= 1'b0;
    end else begin
      rdValidQ <= finishAck && !weQ;
      errQ     <= finishTimeout;
      misQ     <= misDetect;
    end
  end

  assign rdata_o       = rdataQ;
  assign rdata_valid_o = rdValidQ;
  assign bus_err_o     = errQ;
  assign misalign_o    = misQ;
  assign bus_we_o      = weQ;
  assign bus_addr_o    = addrQ;
  assign bus_wdata_o   = wdataQ;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a transaction-level model
// predicts every cycle's outputs, checked by one negedge compare process.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_ack_i    (bus_ack_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chkWdata;
    logic        rdValid;
    logic        err;
    logic        mis;
    logic [31:0] rdata;
  } exp_t;

  exp_t expQ[$];

  int testCount = 0;
  int failCount = 0;

  logic [31:0] mRdata  = '0;
  logic        prevMis = 1'b0;

  int stallRun = 0, lastStall = 0;
  int reqRun = 0, lastReq = 0;
  int errCount = 0, validCount = 0, misCount = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    testCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int req);
    testCount++;
    if (act != req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: tracks pulse/run statistics and checks each queued cycle.
  always @(negedge clk) begin
    exp_t e;
    if (stall_o) stallRun++;
    else begin
      if (stallRun > 0) lastStall = stallRun;
      stallRun = 0;
    end
    if (bus_req_o) reqRun++;
    else begin
      if (reqRun > 0) lastReq = reqRun;
      reqRun = 0;
    end
    if (bus_err_o) errCount++;
    if (rdata_valid_o) validCount++;
    if (misalign_o) misCount++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check32("stall_o", {31'b0, stall_o}, {31'b0, e.stall});
      check32("bus_req_o", {31'b0, bus_req_o}, {31'b0, e.req});
      check32("rdata_valid_o", {31'b0, rdata_valid_o}, {31'b0, e.rdValid});
      check32("bus_err_o", {31'b0, bus_err_o}, {31'b0, e.err});
      check32("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
      check32("rdata_o", rdata_o, e.rdata);
      if (e.req) begin
        check32("bus_addr_o", bus_addr_o, e.addr);
        check32("bus_we_o", {31'b0, bus_we_o}, {31'b0, e.we});
        if (e.chkWdata) check32("bus_wdata_o", bus_wdata_o, e.wdata);
      end
    end
  end

  function automatic exp_t quietExp();
    exp_t e;
    e.stall = 1'b0; e.req = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0;
    e.chkWdata = 1'b0; e.rdValid = 1'b0; e.err = 1'b0; e.mis = 1'b0;
    e.rdata = mRdata;
    return e;
  endfunction

  task automatic driveCycle(input exp_t e);
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic ack);
    exp_t e;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    addr_i      = $urandom;
    wdata_i     = $urandom;
    bus_ack_i   = ack;
    bus_rdata_i = $urandom;
    e = quietExp();
    e.mis = prevMis;
    prevMis = 1'b0;
    driveCycle(e);
  endtask

  // One EX/MEM request. ackAt is the REQ cycle (0-based) carrying the ack;
  // a negative or too-late ackAt means the memory never answers.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd,
                               input logic rd, input logic wr,
                               input int ackAt, input logic [31:0] busData);
    exp_t e;
    logic acked;
    int   nReq;
    addr_i = a; wdata_i = wd; mem_read_i = rd; mem_write_i = wr;
    if (!(rd || wr)) begin
      bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
      e = quietExp(); e.mis = prevMis; prevMis = 1'b0;
      driveCycle(e);
    end else if (a[1:0] != 2'b00) begin
      bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
      e = quietExp(); e.mis = prevMis; prevMis = 1'b1;
      driveCycle(e);
    end else begin
      acked = (ackAt >= 0) && (ackAt < TIMEOUT);
      nReq  = acked ? ackAt + 1 : TIMEOUT;
      bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
      e = quietExp(); e.stall = 1'b1; e.mis = prevMis; prevMis = 1'b0;
      driveCycle(e);
      for (int i = 0; i < nReq; i++) begin
        bus_ack_i   = acked && (i == ackAt);
        bus_rdata_i = (acked && i == ackAt) ? busData : $urandom;
        e = quietExp();
        e.stall = 1'b1; e.req = 1'b1; e.we = wr;
        e.addr = {a[31:2], 2'b00}; e.wdata = wd; e.chkWdata = wr;
        driveCycle(e);
      end
      if (!wr) mRdata = acked ? busData : 32'h0;
      bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
      e = quietExp();
      e.rdValid = !wr && acked;
      e.err     = !acked;
      driveCycle(e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0, e0, m0;
    logic [31:0] ra;
    exp_t e;
    rst = 1'b1; addr_i = '0; wdata_i = '0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset stall_o", {31'b0, stall_o}, 32'h0);
    check32("reset bus_req_o", {31'b0, bus_req_o}, 32'h0);
    check32("reset rdata_o", rdata_o, 32'h0);
    check32("reset bus_addr_o", bus_addr_o, 32'h0);
    check32("reset pulses", {29'b0, rdata_valid_o, misalign_o, bus_err_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycle(1'b1);

    v0 = validCount;
    applyStimulus(32'h100, 32'h0, 1'b1, 1'b0, 0, 32'hDEADBEEF);
    checkInt("load stall length", lastStall, 2);
    check32("load rdata_o", rdata_o, 32'hDEADBEEF);
    checkInt("load valid pulses", validCount - v0, 1);

    v0 = validCount;
    applyStimulus(32'h204, 32'h12345678, 1'b0, 1'b1, 3, 32'hFFFF0000);
    checkInt("store stall length", lastStall, 5);
    checkInt("store valid pulses", validCount - v0, 0);

    m0 = misCount;
    applyStimulus(32'h102, 32'h0, 1'b1, 1'b0, 0, 32'h0);
    idleCycle(1'b0);
    checkInt("misalign pulses", misCount - m0, 1);

    e0 = errCount;
    applyStimulus(32'h180, 32'h0, 1'b1, 1'b0, -1, 32'h0);
    checkInt("timeout req length", lastReq, 16);
    checkInt("timeout err pulses", errCount - e0, 1);
    check32("timeout rdata_o", rdata_o, 32'h0);

    v0 = validCount;
    applyStimulus(32'h40, 32'hCAFE0040, 1'b1, 1'b1, 1, 32'h55AA55AA);
    checkInt("both-flags valid pulses", validCount - v0, 0);
    idleCycle(1'b0);

    // Reset two cycles into a wait, with the load still presented.
    addr_i = 32'h300; wdata_i = '0; mem_read_i = 1'b1; mem_write_i = 1'b0;
    bus_ack_i = 1'b0;
    e = quietExp(); e.stall = 1'b1; e.mis = prevMis; prevMis = 1'b0;
    driveCycle(e);
    for (int i = 0; i < 2; i++) begin
      e = quietExp(); e.stall = 1'b1; e.req = 1'b1; e.addr = 32'h300;
      driveCycle(e);
    end
    #3 rst = 1'b1;
    #1;
    check32("mid-REQ reset bus_req_o", {31'b0, bus_req_o}, 32'h0);
    check32("mid-REQ reset stall_o", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    mem_read_i = 1'b0;
    rst = 1'b0;
    mRdata = '0; prevMis = 1'b0;
    idleCycle(1'b1);
    v0 = validCount;
    applyStimulus(32'h104, 32'h0, 1'b1, 1'b0, 1, 32'hA5A5F00D);
    check32("post-reset load rdata_o", rdata_o, 32'hA5A5F00D);
    checkInt("post-reset valid pulses", validCount - v0, 1);

    for (int t = 0; t < 80; t++) begin
      int kind, ackAt;
      logic rd, wr;
      kind = $urandom_range(0, 9);
      ra = $urandom;
      if (kind < 7) ra[1:0] = 2'b00;
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr && kind < 8) rd = 1'b1;
      ackAt = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      applyStimulus(ra, $urandom, rd, wr, ackAt, $urandom);
      if ($urandom_range(0, 1) == 1) idleCycle(1'($urandom));
    end
    idleCycle(1'b0);
    idleCycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
